// File: rtl/spectro_column_buffer.sv
// spectro_column_buffer: collects one FFT frame of magnitude samples into a
// column and ping-pongs two column banks so the display reader can scan one
// complete column while the next one fills.
// Optional feature macro: PEAK_HOLD_DECAY_EN (decaying peak-hold write data).
module spectro_column_buffer #(
  parameter int N    = 7,   // MSB index of magnitude data
  parameter int BINS = 64,  // bins per column, power of two, >= 4
  parameter int AW   = 6    // read address width, >= log2(BINS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N:0]    mag_in,
  input  logic          mag_valid,
  input  logic          frame_start,
  output logic          mag_ready,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [N:0]    rd_data,
  output logic          rd_valid,
  input  logic          rd_release,
  output logic          col_done,
  output logic [15:0]   col_count,
  output logic          sync_err
);

  localparam int BW = $clog2(BINS);
  localparam logic [AW:0] BINS_W = (AW+1)'(BINS);
  localparam logic [BW-1:0] LAST_BIN = BW'(BINS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD, SWAP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          w_mag_ready;
  logic          w_col_done;
  logic [BW-1:0] r_wr_addr;
  logic          r_wr_bank;     // bank being filled; display bank is ~r_wr_bank
  logic          r_released;    // reader finished with display bank
  logic          r_filled;      // display bank has ever held a complete column
  logic [15:0]   r_col_count;
  logic          r_sync_err;
  logic [N:0]    r_rd_data;
  logic          r_rd_valid;

  // Both banks share one array, indexed by {bank, bin}.
  logic [N:0]    r_mem [0:2*BINS-1];

  logic          w_accept;
  logic          w_last;
  logic          w_wr_en;
  logic [BW-1:0] w_wr_idx;
  logic [N:0]    w_wr_data;
  logic          w_rd_in_range;

  assign w_accept      = mag_valid & w_mag_ready;
  assign w_last        = (r_wr_addr == LAST_BIN);
  assign w_wr_en       = ~reset & w_accept &
                         (((r_state == IDLE) & frame_start) | (r_state == FILL));
  assign w_wr_idx      = frame_start ? '0 : r_wr_addr;
  assign w_rd_in_range = ({1'b0, rd_addr} < BINS_W);

`ifdef PEAK_HOLD_DECAY_EN
  logic [N:0] w_prev;
  logic [N:0] w_decay;
  assign w_prev    = r_filled ? r_mem[{~r_wr_bank, w_wr_idx}] : '0;
  assign w_decay   = (w_prev == '0) ? '0 : w_prev - 1'b1;
  assign w_wr_data = (mag_in > w_decay) ? mag_in : w_decay;
`else
  assign w_wr_data = mag_in;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    // NOTE: sequential state always uses non-blocking assignment so every
    // register samples pre-edge values regardless of block ordering.
    else       r_state <= w_next;
  end

  // Next-state decode and Moore handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next      = r_state;
    w_mag_ready = 1'b1;
    w_col_done  = 1'b0;
    case (r_state)
      IDLE: if (w_accept && frame_start) w_next = FILL;
      FILL: if (w_accept && !frame_start && w_last)
              w_next = (r_released || rd_release) ? SWAP : HOLD;
      HOLD: begin
        w_mag_ready = 1'b0;
        if (rd_release) w_next = SWAP;
      end
      SWAP: begin
        w_mag_ready = 1'b0;
        w_col_done  = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Write address, bank ownership, release/filled flags and status counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_addr   <= '0;
      r_wr_bank   <= 1'b0;
      r_released  <= 1'b1;
      r_filled    <= 1'b0;
      r_col_count <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      if (w_accept && frame_start && (r_state == IDLE || r_state == FILL)) begin
        r_wr_addr <= BW'(1);
        if (r_state == FILL) r_sync_err <= 1'b1;
      end else if (w_accept && r_state == FILL) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end

      if (r_state == SWAP) begin
        r_wr_bank   <= ~r_wr_bank;
        r_filled    <= 1'b1;
        r_released  <= 1'b0;
        r_col_count <= r_col_count + 1'b1;
      end else if (rd_release) begin
        r_released  <= 1'b1;
      end
    end
  end

  // Column storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the storage array is deliberately not reset; r_filled alone says
    // whether the display bank holds meaningful data.
    if (w_wr_en) r_mem[{r_wr_bank, w_wr_idx}] <= w_wr_data;
  end

  // Registered display-bank read; rd_data holds when no read is requested.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en)
        r_rd_data <= (w_rd_in_range && r_filled) ?
                     r_mem[{~r_wr_bank, rd_addr[BW-1:0]}] : '0;
    end
  end

  assign mag_ready = w_mag_ready;
  assign col_done  = w_col_done;
  assign col_count = r_col_count;
  assign sync_err  = r_sync_err;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_spectro_column_buffer.sv
// Directed bench for spectro_column_buffer with BINS=8 and a 4-bit read
// address so out-of-range bins can be requested. Expected values for the
// peak-hold columns follow PEAK_HOLD_DECAY_EN when defined.
module tb_spectro_column_buffer;

  localparam int N    = 7;
  localparam int BINS = 8;
  localparam int AW   = 4;

  logic          clock;
  logic          reset;
  logic [N:0]    mag_in;
  logic          mag_valid;
  logic          frame_start;
  logic          mag_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N:0]    rd_data;
  logic          rd_valid;
  logic          rd_release;
  logic          col_done;
  logic [15:0]   col_count;
  logic          sync_err;

  int n_vec = 0;
  int n_err = 0;

`ifdef PEAK_HOLD_DECAY_EN
  localparam logic [7:0] EXP_B  = 8'd99;
  localparam logic [7:0] EXP_C0 = 8'd98;
`else
  localparam logic [7:0] EXP_B  = 8'd40;
  localparam logic [7:0] EXP_C0 = 8'd0;
`endif

  spectro_column_buffer #(.N(N), .BINS(BINS), .AW(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .mag_in      (mag_in),
    .mag_valid   (mag_valid),
    .frame_start (frame_start),
    .mag_ready   (mag_ready),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_release  (rd_release),
    .col_done    (col_done),
    .col_count   (col_count),
    .sync_err    (sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [N:0] v, input logic fs);
    check("mag_ready before send", mag_ready, 1);
    mag_in      = v;
    frame_start = fs;
    mag_valid   = 1'b1;
    tick();
    mag_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_col(input logic [N:0] base, input logic [N:0] inc);
    for (int i = 0; i < BINS; i++) send(base + N'(i) * inc, i == 0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [N:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
    check({tag, " rd_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    tick();
    rd_release = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mag_ready"}, mag_ready, 1);
    check({tag, " rd_data"},   rd_data,   0);
    check({tag, " rd_valid"},  rd_valid,  0);
    check({tag, " col_done"},  col_done,  0);
    check({tag, " col_count"}, col_count, 0);
    check({tag, " sync_err"},  sync_err,  0);
  endtask

  initial begin
    reset = 1'b1; mag_in = '0; mag_valid = 1'b0; frame_start = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
    #23;
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Reads before any column completes return zero.
    rd(3, 0, "unfilled bin3");
    tick();
    check("rd_valid idle", rd_valid, 0);

    // First column 0..7 goes straight to the display side.
    send_col(0, 1);
    check("col1 col_done", col_done, 1);
    tick();
    check("col1 col_done pulse", col_done, 0);
    check("col1 count", col_count, 1);
    rd(9, 0, "out of range bin9");
    rd(5, 5, "col1 bin5");
    tick();
    check("rd_data hold", rd_data, 5);
    check("rd_valid low", rd_valid, 0);

    // Second column with display bank unreleased stalls in HOLD.
    send_col(10, 1);
    check("hold mag_ready", mag_ready, 0);
    check("hold col_done", col_done, 0);
    repeat (3) tick();
    check("hold wait mag_ready", mag_ready, 0);
    check("hold wait col_done", col_done, 0);
    rd(5, 5, "hold old display bin5");
    release_bank();
    check("col2 col_done", col_done, 1);
    tick();
    check("col2 count", col_count, 2);
    check("col2 mag_ready", mag_ready, 1);
    rd(5, 15, "col2 bin5");

    // Resync: frame_start on the 4th sample restarts the column.
    release_bank();
    send(20, 1); send(21, 0); send(22, 0);
    check("sync_err before", sync_err, 0);
    send(50, 1);
    check("sync_err set", sync_err, 1);
    for (int i = 1; i < BINS; i++) begin
      if (i == BINS - 1) check("resync col_done early", col_done, 0);
      send(8'(50 + i), 0);
    end
    check("resync col_done", col_done, 1);
    tick();
    check("resync count", col_count, 3);
    check("sync_err sticky", sync_err, 1);
    rd(0, 50, "resync bin0");
    rd(7, 57, "resync bin7");

    // Reset mid-column.
    release_bank();
    send(60, 1);
    for (int i = 1; i < 5; i++) send(8'(60 + i), 0);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    #2 reset = 1'b0;
    tick();
    send_col(70, 1);
    check("post reset col_done", col_done, 1);
    tick();
    check("post reset count", col_count, 1);
    rd(3, 73, "post reset bin3");

    // Peak-hold columns: A all 100, B all 40, C bin2=120 others 0.
    release_bank();
    send_col(100, 0);
    tick();
    release_bank();
    send_col(40, 0);
    tick();
    rd(0, EXP_B, "colB bin0");
    rd(7, EXP_B, "colB bin7");
    release_bank();
    for (int i = 0; i < BINS; i++) send((i == 2) ? 8'd120 : 8'd0, i == 0);
    tick();
    check("colC count", col_count, 4);
    rd(2, 120, "colC bin2");
    rd(0, EXP_C0, "colC bin0");
    rd(5, EXP_C0, "colC bin5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spectro_column_buffer.md
Name: spectro_column_buffer

Overview:
- Sits directly downstream of the magnitude-approximation stage (|Re|,|Im| -> magnitude).
- Collects one FFT frame of magnitude samples, one per bin, into a column.
- Ping-pong buffers the columns so the display/scroll logic can read one complete column while the next column fills.
- Provides valid/ready flow control upstream and a release handshake with the display reader.

Parameters:
N, 7, MSB index of magnitude data (data width N+1, matches magnitude stage)
BINS, 64, bins per column (power of two, >=4)
AW, 6, address width, log2(BINS)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
mag_in  input  N+1  magnitude sample from magnitude stage
mag_valid  input  1  mag_in valid this cycle
frame_start  input  1  qualifies mag_in as bin 0 of a new frame (sampled only with mag_valid)
mag_ready  output  1  block can accept a sample this cycle
rd_en  input  1  display read request
rd_addr  input  AW  bin index to read from display bank
rd_data  output  N+1  read data
rd_valid  output  1  rd_data valid
rd_release  input  1  single-cycle pulse: reader finished with display bank
col_done  output  1  single-cycle pulse: new column swapped to display side
col_count  output  16  completed-column counter
sync_err  output  1  sticky: frame_start seen mid-column

Behaviour:
- Interface decision: one clock (clock); reset (reset) is asynchronous and active-high.
- Reset values:
  - Outputs: mag_ready=1, rd_data=0, rd_valid=0, col_done=0, col_count=0, sync_err=0.
  - Internal: write bank=A, display bank "released" and "never filled", state IDLE.
- Transfer: a sample is accepted when mag_valid && mag_ready in the same cycle.
- FSM states: IDLE, FILL, HOLD, SWAP.
  - IDLE:
    - mag_ready=1.
    - An accepted sample without frame_start is dropped.
    - An accepted sample with frame_start is written at bin 0, wr_addr=1, then -> FILL.
  - FILL:
    - mag_ready=1; each accepted sample is written at wr_addr and wr_addr increments.
    - Accepted sample with frame_start: partial column discarded, sample written at bin 0, wr_addr=1, sync_err set, stay FILL.
    - On acceptance at wr_addr=BINS-1: -> SWAP if display bank released (or rd_release pulses in that same cycle), else -> HOLD.
  - HOLD:
    - mag_ready=0.
    - Wait for rd_release, then -> SWAP.
    - Upstream must stall; no data is lost.
  - SWAP:
    - One cycle, mag_ready=0.
    - Toggle write/display banks; display bank marked filled and not released.
    - col_done=1 for this cycle only; col_count increments (wraps 0xFFFF->0).
    - -> IDLE.
- Latency: last-bin acceptance to col_done is 1 cycle (direct) or 1 cycle after rd_release (via HOLD).
- Read port:
  - rd_en at cycle t gives rd_data/rd_valid at t+1; rd_valid=0 when rd_en=0, and rd_data holds its last value.
  - rd_data=0 if rd_addr>=BINS or the display bank was never filled.
  - Reads always target the display bank; a read in the SWAP cycle returns the old display bank.
- rd_release when already released: ignored.
- Reset asserted mid-column: partial column lost, everything returns to reset values immediately.
- Column storage is not cleared by reset; validity is tracked by the filled flag only.

Optional Feature:
- Macro: PEAK_HOLD_DECAY_EN.
- Defined: the value written for bin k is max(mag_in, prev_k - 1).
  - prev_k is the display bank's bin k value, saturating at 0.
  - prev=0 when the display bank was never filled.
  - This gives a decaying peak trace.
- Undefined: mag_in is written unmodified.
- Handshake and latency are identical in both builds.

Test Plan:
1. Reset, BINS=8: stream 0..7 with frame_start on the first sample -> col_done one cycle after the 8th sample, col_count=1; rd_addr=5 gives rd_data=5 one cycle later with rd_valid=1.
2. Before any column completes: rd_en, rd_addr=3 -> rd_data=0, rd_valid=1. rd_addr=9 (BINS=8) after a column -> rd_data=0.
3. Fill column 1 without rd_release, then fill column 2 -> HOLD entered, mag_ready=0, no col_done. Pulse rd_release -> col_done next cycle, col_count=2.
4. frame_start at the 4th sample of a column -> sync_err=1 (sticky). The column completes 8 samples later counting from the resync sample, and bin 0 holds the resync sample value.
5. Assert reset while 5 of 8 bins are filled -> outputs immediately at reset values; a following full column yields col_count=1.
6. PEAK_HOLD_DECAY_EN: column A all 100, column B all 40 -> bins read 99. Column C with bin 2=120, others 0 -> bin 2 reads 120, others 98.
